// File: rtl/alu_writeback_stage_pkg.sv
// Shared constants and types for the ALU writeback stage: datapath widths,
// the queued entry layout and the status-flag parity helper.
package alu_writeback_stage_pkg;

    localparam int WORD_SIZE    = 19;
    localparam int REG_ADDR_W   = 4;
    localparam int DEPTH        = 2;
    localparam int RETIRE_CNT_W = 16;

    typedef struct packed {
        logic [WORD_SIZE-1:0]  result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wb_en;
    } wb_entry_t;

    function automatic logic odd_parity(input logic [WORD_SIZE-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Result-capture and register-file write handshake bundle of the writeback stage.
interface alu_writeback_stage_if;

    logic                                          in_valid;
    logic                                          in_ready;
    logic [alu_writeback_stage_pkg::WORD_SIZE-1:0]  in_result;
    logic [alu_writeback_stage_pkg::REG_ADDR_W-1:0] in_rd;
    logic                                          in_wb_en;
    logic                                          wr_valid;
    logic                                          wr_ready;
    logic [alu_writeback_stage_pkg::REG_ADDR_W-1:0] wr_addr;
    logic [alu_writeback_stage_pkg::WORD_SIZE-1:0]  wr_data;

    modport master (
        output in_valid, in_result, in_rd, in_wb_en, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_result, in_rd, in_wb_en, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );

endinterface

// File: rtl/alu_writeback_stage_flag_calc.sv
// Combinational zero / sign / odd-parity flag derivation for one result word.
module wb_flag_calc
    import alu_writeback_stage_pkg::*;
(
    input  logic [WORD_SIZE-1:0] i_word,
    output logic                 o_z,
    output logic                 o_n,
    output logic                 o_p
);

    assign o_z = (i_word == {WORD_SIZE{1'b0}});
    assign o_n = i_word[WORD_SIZE-1];
    assign o_p = odd_parity(i_word);

endmodule

// File: rtl/alu_writeback_stage.sv
// Two-entry in-order writeback queue: drives the register-file write port,
// retires flags and counts retirements, and offers a bypass lookup on pending results.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    alu_writeback_stage_if.slave    bus,
    input  logic [REG_ADDR_W-1:0]   i_fwd_rd,
    output logic                    o_fwd_hit,
    output logic [WORD_SIZE-1:0]    o_fwd_data,
    output logic                    o_flag_z,
    output logic                    o_flag_n,
    output logic                    o_flag_p,
    output logic [1:0]              o_count,
    output logic [RETIRE_CNT_W-1:0] o_retired
);

    // r_ent0 is always the head (oldest); r_ent1 is only meaningful when full
    wb_entry_t               r_ent0;
    wb_entry_t               r_ent1;
    logic [1:0]              r_count;
    logic                    r_flag_z;
    logic                    r_flag_n;
    logic                    r_flag_p;
    logic [RETIRE_CNT_W-1:0] r_retired;

    wb_entry_t  w_new;
    wb_entry_t  w_ent0_nxt;
    wb_entry_t  w_ent1_nxt;
    logic [1:0] w_count_nxt;
    logic       w_head_valid;
    logic       w_tail_valid;
    logic       w_push;
    logic       w_pop;
    logic       w_z;
    logic       w_n;
    logic       w_p;

    assign w_head_valid = (r_count != 2'd0);
    assign w_tail_valid = (r_count == 2'd2);
    assign bus.in_ready = (r_count < 2'd2);
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_pop        = w_head_valid && (bus.wr_ready || !r_ent0.wb_en);

    assign w_new.result = bus.in_result;
    assign w_new.rd     = bus.in_rd;
    assign w_new.wb_en  = bus.in_wb_en;

    assign bus.wr_valid = w_head_valid && r_ent0.wb_en;
    assign bus.wr_addr  = w_head_valid ? r_ent0.rd     : {REG_ADDR_W{1'b0}};
    assign bus.wr_data  = w_head_valid ? r_ent0.result : {WORD_SIZE{1'b0}};

    assign o_count   = r_count;
    assign o_retired = r_retired;
    assign o_flag_z  = r_flag_z;
    assign o_flag_n  = r_flag_n;
    assign o_flag_p  = r_flag_p;

    wb_flag_calc u_flag_calc (
        .i_word (r_ent0.result),
        .o_z    (w_z),
        .o_n    (w_n),
        .o_p    (w_p)
    );

    // Queue next-state; push+pop can only coincide at count=1, so the new entry becomes head
    always_comb begin
        w_ent0_nxt  = r_ent0;
        w_ent1_nxt  = r_ent1;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_count == 2'd0) begin
                    w_ent0_nxt = w_new;
                end else begin
                    w_ent1_nxt = w_new;
                end
                w_count_nxt = r_count + 2'd1;
            end
            2'b01: begin
                w_ent0_nxt  = r_ent1;
                w_count_nxt = r_count - 2'd1;
            end
            2'b11: begin
                w_ent0_nxt = w_new;
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
    end

    // Bypass lookup: the younger tail entry takes priority over the head
    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = {WORD_SIZE{1'b0}};
        if (w_tail_valid && r_ent1.wb_en && (r_ent1.rd == i_fwd_rd)) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = r_ent1.result;
        end else if (w_head_valid && r_ent0.wb_en && (r_ent0.rd == i_fwd_rd)) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = r_ent0.result;
        end else begin
            o_fwd_hit  = 1'b0;
            o_fwd_data = {WORD_SIZE{1'b0}};
        end
    end

    // Queue storage, occupancy, retire flags and retirement counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ent0    <= '{result: {WORD_SIZE{1'b0}}, rd: {REG_ADDR_W{1'b0}}, wb_en: 1'b0};
            r_ent1    <= '{result: {WORD_SIZE{1'b0}}, rd: {REG_ADDR_W{1'b0}}, wb_en: 1'b0};
            r_count   <= 2'd0;
            r_flag_z  <= 1'b0;
            r_flag_n  <= 1'b0;
            r_flag_p  <= 1'b0;
            r_retired <= {RETIRE_CNT_W{1'b0}};
        end else begin
            r_ent0  <= w_ent0_nxt;
            r_ent1  <= w_ent1_nxt;
            r_count <= w_count_nxt;
            if (w_pop) begin
                r_flag_z  <= w_z;
                r_flag_n  <= w_n;
                r_flag_p  <= w_p;
                r_retired <= r_retired + {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: table-driven single-entry vectors,
// hand-written multi-cycle sequences, and a write-order scoreboard.
module tb_alu_writeback_stage;
    import alu_writeback_stage_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic [REG_ADDR_W-1:0]   fwd_rd;
    logic                    fwd_hit;
    logic [WORD_SIZE-1:0]    fwd_data;
    logic                    flag_z, flag_n, flag_p;
    logic [1:0]              count;
    logic [RETIRE_CNT_W-1:0] retired;

    int n_checks;
    int n_errors;
    int exp_retired;

    alu_writeback_stage_if bus();

    alu_writeback_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .i_fwd_rd   (fwd_rd),
        .o_fwd_hit  (fwd_hit),
        .o_fwd_data (fwd_data),
        .o_flag_z   (flag_z),
        .o_flag_n   (flag_n),
        .o_flag_p   (flag_p),
        .o_count    (count),
        .o_retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_SIZE-1:0]  result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wb_en;
        logic                  wr_ready;
        logic                  z;
        logic                  n;
        logic                  p;
    } vec_t;

    typedef struct {
        logic [REG_ADDR_W-1:0] addr;
        logic [WORD_SIZE-1:0]  data;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected writes enqueued on acceptance, compared when a write handshake completes
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.wr_valid && bus.wr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected_write: got addr=0x%0h data=0x%0h expected no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("sb_wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                    chk("sb_wr_data", 32'(bus.wr_data), 32'(e.data));
                end
            end
            if (bus.in_valid && bus.in_ready && bus.in_wb_en) begin
                exp_q.push_back('{addr: bus.in_rd, data: bus.in_result});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WORD_SIZE-1:0] res,
                         input logic [REG_ADDR_W-1:0] rd, input logic wb);
        bus.in_valid  = v;
        bus.in_result = res;
        bus.in_rd     = rd;
        bus.in_wb_en  = wb;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        exp_retired = 0;

        vecs[0] = '{result: 19'h00000, rd: 4'd3,  wb_en: 1'b1, wr_ready: 1'b1, z: 1'b1, n: 1'b0, p: 1'b0};
        vecs[1] = '{result: 19'h40001, rd: 4'd5,  wb_en: 1'b1, wr_ready: 1'b1, z: 1'b0, n: 1'b1, p: 1'b0};
        vecs[2] = '{result: 19'h00001, rd: 4'd1,  wb_en: 1'b0, wr_ready: 1'b0, z: 1'b0, n: 1'b0, p: 1'b1};
        vecs[3] = '{result: 19'h7FFFF, rd: 4'd15, wb_en: 1'b1, wr_ready: 1'b1, z: 1'b0, n: 1'b1, p: 1'b1};
        vecs[4] = '{result: 19'h00007, rd: 4'd6,  wb_en: 1'b1, wr_ready: 1'b1, z: 1'b0, n: 1'b0, p: 1'b1};
        vecs[5] = '{result: 19'h3FFFF, rd: 4'd0,  wb_en: 1'b0, wr_ready: 1'b0, z: 1'b0, n: 1'b0, p: 1'b0};

        rst_n        = 1'b0;
        bus.wr_ready = 1'b0;
        fwd_rd       = 4'd0;
        drive(1'b0, 19'h0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_count",    32'(count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_retired",  32'(retired), 32'd0);
        chk("rst_flags",    32'({flag_z, flag_n, flag_p}), 32'd0);
        chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("rst_wr_data",  32'(bus.wr_data), 32'd0);
        chk("rst_fwd_hit",  32'(fwd_hit), 32'd0);

        // Single-entry vectors from an empty queue
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.wr_ready = vecs[i].wr_ready;
            drive(1'b1, vecs[i].result, vecs[i].rd, vecs[i].wb_en);
            tick();
            drive(1'b0, 19'h0, 4'd0, 1'b0);
            @(negedge clk);
            chk("vec_wr_valid", 32'(bus.wr_valid), 32'(vecs[i].wb_en));
            chk("vec_wr_addr",  32'(bus.wr_addr), 32'(vecs[i].rd));
            chk("vec_wr_data",  32'(bus.wr_data), 32'(vecs[i].result));
            chk("vec_count1",   32'(count), 32'd1);
            @(posedge clk);
            exp_retired++;
            @(negedge clk);
            chk("vec_count0",  32'(count), 32'd0);
            chk("vec_flags",   32'({flag_z, flag_n, flag_p}), 32'({vecs[i].z, vecs[i].n, vecs[i].p}));
            chk("vec_retired", 32'(retired), 32'(exp_retired));
            chk("vec_empty_addr", 32'(bus.wr_addr), 32'd0);
        end

        // Backpressure: fill, refuse a third, hold head, then drain in order
        tick();
        bus.wr_ready = 1'b0;
        drive(1'b1, 19'h40001, 4'd5, 1'b1);
        tick();
        drive(1'b1, 19'h00007, 4'd6, 1'b1);
        tick();
        drive(1'b1, 19'h12345, 4'd7, 1'b1);
        @(negedge clk);
        chk("bp_count2",   32'(count), 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_wr_data",  32'(bus.wr_data), 32'h40001);
        tick();
        @(negedge clk);
        chk("bp_refused",  32'(count), 32'd2);
        chk("bp_hold",     32'(bus.wr_data), 32'h40001);
        chk("bp_hold_adr", 32'(bus.wr_addr), 32'd5);
        tick();
        drive(1'b0, 19'h0, 4'd0, 1'b0);
        bus.wr_ready = 1'b1;
        tick();
        exp_retired++;
        @(negedge clk);
        chk("bp_flags_a",  32'({flag_z, flag_n, flag_p}), 32'b010);
        chk("bp_next_adr", 32'(bus.wr_addr), 32'd6);
        chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
        tick();
        exp_retired++;
        @(negedge clk);
        chk("bp_drained",  32'(count), 32'd0);
        chk("bp_retired",  32'(retired), 32'(exp_retired));

        // Simultaneous push and pop at count=1
        tick();
        drive(1'b1, 19'h00111, 4'd8, 1'b1);
        tick();
        drive(1'b1, 19'h00222, 4'd9, 1'b1);
        @(negedge clk);
        chk("pp_head_x", 32'(bus.wr_addr), 32'd8);
        tick();
        exp_retired++;
        drive(1'b0, 19'h0, 4'd0, 1'b0);
        @(negedge clk);
        chk("pp_count", 32'(count), 32'd1);
        chk("pp_head_y", 32'(bus.wr_addr), 32'd9);
        chk("pp_data_y", 32'(bus.wr_data), 32'h00222);
        tick();
        exp_retired++;

        // Forwarding over two pending rd=2 entries
        bus.wr_ready = 1'b0;
        drive(1'b1, 19'h00011, 4'd2, 1'b1);
        tick();
        drive(1'b1, 19'h00022, 4'd2, 1'b1);
        tick();
        drive(1'b0, 19'h0, 4'd0, 1'b0);
        fwd_rd = 4'd2;
        @(negedge clk);
        chk("fwd_hit_young",  32'(fwd_hit), 32'd1);
        chk("fwd_data_young", 32'(fwd_data), 32'h00022);
        fwd_rd = 4'd4;
        #1;
        chk("fwd_miss_hit",  32'(fwd_hit), 32'd0);
        chk("fwd_miss_data", 32'(fwd_data), 32'd0);
        tick();
        fwd_rd = 4'd2;
        bus.wr_ready = 1'b1;
        tick();
        exp_retired++;
        @(negedge clk);
        chk("fwd_after_pop", 32'(fwd_data), 32'h00022);
        tick();
        exp_retired++;
        @(negedge clk);
        chk("fwd_empty_hit", 32'(fwd_hit), 32'd0);
        chk("fwd_retired",   32'(retired), 32'(exp_retired));

        // Reset mid-handshake with flags set and a full queue
        tick();
        bus.wr_ready = 1'b0;
        drive(1'b1, 19'h7FFFF, 4'd0, 1'b0);
        tick();
        drive(1'b0, 19'h0, 4'd0, 1'b0);
        tick();
        exp_retired++;
        drive(1'b1, 19'h00aaa, 4'd10, 1'b1);
        tick();
        drive(1'b1, 19'h00bbb, 4'd11, 1'b1);
        tick();
        drive(1'b0, 19'h0, 4'd0, 1'b0);
        @(negedge clk);
        chk("mr_pre_count", 32'(count), 32'd2);
        chk("mr_pre_valid", 32'(bus.wr_valid), 32'd1);
        chk("mr_pre_flags", 32'({flag_z, flag_n, flag_p}), 32'b011);
        chk("mr_pre_retired", 32'(retired), 32'(exp_retired));
        tick();
        rst_n = 1'b0;
        bus.wr_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        exp_retired = 0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mr_count",    32'(count), 32'd0);
        chk("mr_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("mr_flags",    32'({flag_z, flag_n, flag_p}), 32'd0);
        chk("mr_retired",  32'(retired), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("mr_still_empty", 32'(count), 32'd0);

        // Retirement counter wrap via a stream of flags-only entries
        tick();
        bus.wr_ready = 1'b0;
        drive(1'b1, 19'h00001, 4'd1, 1'b0);
        repeat (65536) @(posedge clk);
        #1;
        drive(1'b0, 19'h0, 4'd0, 1'b0);
        @(negedge clk);
        chk("wrap_pre",       32'(retired), 32'hFFFF);
        chk("wrap_pre_count", 32'(count), 32'd1);
        tick();
        @(negedge clk);
        chk("wrap_retired", 32'(retired), 32'd0);
        chk("wrap_count",   32'(count), 32'd0);
        chk("wrap_flags",   32'({flag_z, flag_n, flag_p}), 32'b001);
        chk("wrap_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("sb_drained",   32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Downstream stage of the logical unit: captures each ALU result together with its destination register index.
- Buffers results in a 2-entry in-order queue and drives the register-file write port through a valid/ready handshake.
- Registers the Z/N/P status flags as each result retires.
- Exposes a combinational forwarding lookup over pending entries so the operand stage can bypass results not yet written.

Parameters:
- WORD_SIZE, 19, datapath width; comes from the constants package.
- REG_ADDR_W, 4, register index width (16 architectural registers).
- DEPTH, 2, queue entries; only 2 is supported.
- RETIRE_CNT_W, 16, width of the retired-result counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept a result.
- in_result  in  WORD_SIZE  ALU output word.
- in_rd  in  REG_ADDR_W  destination register.
- in_wb_en  in  1  1 = write the register file; 0 = update flags only.
- wr_valid  out  1  register-file write request.
- wr_ready  in  1  register file accepts the write.
- wr_addr  out  REG_ADDR_W  write address (head entry rd).
- wr_data  out  WORD_SIZE  write data (head entry result).
- flag_z / flag_n / flag_p  out  1 each  zero / sign (MSB) / odd-parity flags of the last retired result.
- fwd_rd  in  REG_ADDR_W  forwarding query register.
- fwd_hit  out  1  a pending entry with wb_en=1 targets fwd_rd.
- fwd_data  out  WORD_SIZE  result of the youngest matching entry; 0 when no hit.
- count  out  2  occupancy, 0..2.
- retired  out  RETIRE_CNT_W  number of entries retired since reset; wraps.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - count=0, retired=0, all flags 0; queue contents discarded.
  - Pending writes are dropped, including any wr_valid that was high mid-handshake.
  - in_ready=1 from the first edge after reset deasserts.
- Ready and push:
  - in_ready = (count < 2). It is purely a function of count, with no combinational path from wr_ready.
  - Push when in_valid && in_ready. When full, a push is refused even if a pop happens in the same cycle.
- Head outputs and pop:
  - wr_valid = (count > 0) && head.wb_en. wr_addr/wr_data always show the head entry; they are 0 when empty.
  - Pop (retire) when count>0 && (wr_ready || !head.wb_en). A wb_en=0 entry retires in one cycle without a handshake.
  - A head with wb_en=1 holds wr_valid, wr_addr and wr_data stable until wr_ready.
- Latency: a result accepted at edge N appears at the head (wr_valid) at cycle N+1 if the queue was empty.
- Simultaneous push and pop with count=1:
  - count stays 1.
  - The new entry becomes the head in the next cycle.
- Retire effects (on the pop edge):
  - flag_z = (result == 0), flag_n = result[WORD_SIZE-1], flag_p = XOR-reduce of result.
  - retired increments by 1, wrapping 0xFFFF -> 0.
  - Flags otherwise hold.
- Ordering: entries retire strictly in acceptance order.
- Forwarding:
  - Combinational over valid entries with wb_en=1 and rd == fwd_rd.
  - When both entries match, the younger (tail) entry wins.
  - An entry retiring this cycle still counts as a hit this cycle.
- Register 0 gets no special treatment in this stage.

Decomposition:
- Constants package: add REG_ADDR_W and typedef wb_entry_t (result, rd, wb_en). WORD_SIZE is reused.
- One combinational sub-module, wb_flag_calc: maps a word to {z, n, p}.
- The queue, handshake, counter and forwarding mux stay in the top module.

Test Plan:
- Single push: result=0x00000, rd=3, wb_en=1, wr_ready=1 -> wr_valid at N+1 with wr_addr=3. Then flag_z=1, flag_n=0, flag_p=0, retired=1, count=0.
- Backpressure: push 0x40001 (rd=5) and 0x00007 (rd=6) with wr_ready=0.
  - count=2, in_ready=0; a third in_valid is not accepted.
  - wr_data holds 0x40001 stable.
  - Raise wr_ready: writes occur in order 5 then 6, and in_ready returns to 1.
  - After 0x40001 retires: flag_n=1, flag_p=0.
- Flags-only entry: push 0x00001 with wb_en=0 while wr_ready=0 -> wr_valid never rises; entry retires next cycle with flag_p=1; retired increments.
- Forwarding: pending rd=2 entries 0x00011 (older) and 0x00022 (younger) with fwd_rd=2 -> fwd_hit=1, fwd_data=0x00022. With fwd_rd=4 -> fwd_hit=0, fwd_data=0.
- Reset mid-handshake: count=2, wr_valid=1, assert rst_n=0 for one edge -> count=0, wr_valid=0, flags 0, retired=0. No write occurs after reset.
- Counter wrap: force 65536 retirements -> retired wraps to 0 with no other side effects.
